// File: rtl/matrix_scan_ctrl_if.sv
// Game-logic side of the LED matrix scan controller: back-buffer writes,
// swap handshake and the registered matrix pin drive.
interface matrix_scan_ctrl_if;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] rows;
    logic [2:0] col_sel;

    modport master (
        output enable, wr_en, wr_col, wr_data, swap_req,
        input  swap_ack, frame_start, rows, col_sel
    );

    modport slave (
        input  enable, wr_en, wr_col, wr_data, swap_req,
        output swap_ack, frame_start, rows, col_sel
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// 8x8 LED matrix scan controller: double-buffered frame store, column
// multiplexing with a blanking gap before each column, and tear-free
// front/back swap taken only at a frame boundary (or at once while idle).
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | scan disabled, rows/col_sel held at 0
// ST_BLANK | rows forced to 0 for BLANK_CYCLES before lighting col
// ST_SHOW  | front[col] driven onto rows for DWELL_CYCLES
module matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               resetbutton,
    matrix_scan_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]             state_q, state_d;
    logic [2:0]             col_q, col_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   front_sel_q, front_sel_d;
    logic                   swap_pending_q, swap_pending_d;
    logic [1:0][7:0][7:0]   fb_q, fb_d;
    logic [7:0]             rows_q, rows_d;
    logic [2:0]             col_sel_q, col_sel_d;
    logic                   frame_start_q, frame_start_d;
    logic                   swap_ack_q, swap_ack_d;
    logic                   swap_take;

    // Next-state logic; outputs are computed from the next state so the
    // registered pins line up with the state they describe.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        cnt_d         = cnt_q;
        frame_start_d = 1'b0;
        swap_take     = 1'b0;

        if (!bus.enable) begin
            state_d = ST_IDLE;
            col_d   = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d       = ST_BLANK;
                    col_d         = 3'd0;
                    cnt_d         = '0;
                    frame_start_d = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        col_d   = col_q + 3'd1;
                        if (col_q == 3'd7) begin
                            // Frame boundary: a request arriving right now
                            // rides along with this swap.
                            frame_start_d = 1'b1;
                            swap_take     = swap_pending_q | bus.swap_req;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    col_d   = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Nothing is on display while idle, so a pending swap can go now.
        if (state_q == ST_IDLE && swap_pending_q) begin
            swap_take = 1'b1;
        end

        swap_pending_d = swap_take ? 1'b0 : (swap_pending_q | bus.swap_req);
        front_sel_d    = front_sel_q ^ swap_take;
        swap_ack_d     = swap_take;

        // Writes always land in the pre-swap back buffer.
        fb_d = fb_q;
        if (bus.wr_en) begin
            fb_d[~front_sel_q][bus.wr_col] = bus.wr_data;
        end

        col_sel_d = col_d;
        rows_d    = (state_d == ST_SHOW) ? fb_d[front_sel_d][col_d] : 8'h00;
    end

    // State, frame store and registered outputs.
    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            state_q        <= ST_IDLE;
            col_q          <= 3'd0;
            cnt_q          <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            fb_q           <= '0;
            rows_q         <= 8'h00;
            col_sel_q      <= 3'd0;
            frame_start_q  <= 1'b0;
            swap_ack_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            cnt_q          <= cnt_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            fb_q           <= fb_d;
            rows_q         <= rows_d;
            col_sel_q      <= col_sel_d;
            frame_start_q  <= frame_start_d;
            swap_ack_q     <= swap_ack_d;
        end
    end

    assign bus.rows        = rows_q;
    assign bus.col_sel     = col_sel_q;
    assign bus.frame_start = frame_start_q;
    assign bus.swap_ack    = swap_ack_q;

endmodule
